// File: rtl/fetch_pc_if.sv
// Bundles the fetch-stage signals that run between the pipeline and the IM:
// pipeline control in, IM bus, decoder feed and the performance counters.
interface fetch_pc_if #(
  parameter int PC_W = 16
);
  logic            stall_IM_ID;
  logic            flow_change_ID_EX;
  logic [PC_W-1:0] dst_ID_EX;
  logic            hlt_DM_WB;
  logic [PC_W-1:0] iaddr;
  logic [16:0]     im_rdata;
  logic [16:0]     instr;
  logic [PC_W-1:0] nxt_pc_ID_EX;
  logic [31:0]     cyc_cnt;
  logic [15:0]     redir_cnt;
  logic [15:0]     stall_cnt;

  modport slave (
    input  stall_IM_ID, flow_change_ID_EX, dst_ID_EX, hlt_DM_WB, im_rdata,
    output iaddr, instr, nxt_pc_ID_EX, cyc_cnt, redir_cnt, stall_cnt
  );

  modport master (
    output stall_IM_ID, flow_change_ID_EX, dst_ID_EX, hlt_DM_WB, im_rdata,
    input  iaddr, instr, nxt_pc_ID_EX, cyc_cnt, redir_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_pc.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IM address,
// feeds the decoder and pipelines next-PC towards EX, plus perf counters.
module fetch_pc #(
  parameter int PC_W      = 16,
  parameter int RESET_VEC = 0
) (
  input logic       clk,
  input logic       rst_n,
  fetch_pc_if.slave bus
);
  localparam logic [PC_W-1:0] RESET_PC = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

  logic            fetch_vld_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] nxt_pc_IM_ID_q, nxt_pc_IM_ID_d;
  logic [PC_W-1:0] nxt_pc_ID_EX_q;
  logic [31:0]     cyc_cnt_q, cyc_cnt_d;
  logic [15:0]     redir_cnt_q, redir_cnt_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  assign pc_inc = pc_q + PC_ONE;

  // Redirect outranks stall/halt; the first edge after reset always fetches RESET_VEC.
  always_comb begin
    pc_d = pc_inc;
    if (!fetch_vld_q)
      pc_d = RESET_PC;
    else if (bus.flow_change_ID_EX)
      pc_d = bus.dst_ID_EX;
    else if (bus.stall_IM_ID || bus.hlt_DM_WB)
      pc_d = pc_q;
  end

  // Shares its enable with the decoder's IM_ID flop so it tracks instr_IM_ID.
  always_comb begin
    nxt_pc_IM_ID_d = nxt_pc_IM_ID_q;
    if (!bus.stall_IM_ID)
      nxt_pc_IM_ID_d = pc_inc;
  end

  always_comb begin
    cyc_cnt_d   = cyc_cnt_q;
    redir_cnt_d = redir_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!bus.hlt_DM_WB) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
      if (bus.flow_change_ID_EX && !(&redir_cnt_q))
        redir_cnt_d = redir_cnt_q + 16'd1;
      if (bus.stall_IM_ID && !bus.flow_change_ID_EX && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_vld_q    <= 1'b0;
      pc_q           <= RESET_PC;
      nxt_pc_IM_ID_q <= '0;
      nxt_pc_ID_EX_q <= '0;
      cyc_cnt_q      <= '0;
      redir_cnt_q    <= '0;
      stall_cnt_q    <= '0;
    end else begin
      fetch_vld_q    <= 1'b1;
      pc_q           <= pc_d;
      nxt_pc_IM_ID_q <= nxt_pc_IM_ID_d;
      nxt_pc_ID_EX_q <= nxt_pc_IM_ID_q;
      cyc_cnt_q      <= cyc_cnt_d;
      redir_cnt_q    <= redir_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  // Before the first fetch the decoder sees LLB R0,#0, its own reset instruction.
  assign bus.iaddr        = pc_d;
  assign bus.instr        = fetch_vld_q ? bus.im_rdata : 17'h00000;
  assign bus.nxt_pc_ID_EX = nxt_pc_ID_EX_q;
  assign bus.cyc_cnt      = cyc_cnt_q;
  assign bus.redir_cnt    = redir_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_fetch_pc.sv
// Randomized and directed bench for fetch_pc against a cycle-level reference
// model of the fetch rules, with a synchronous IM whose words derive from address.
module tb_fetch_pc;
  logic clk;
  logic rst_n;

  fetch_pc_if #(.PC_W(16)) bus ();

  fetch_pc #(.PC_W(16), .RESET_VEC(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors;
  int miscompares;

  logic        mVld;
  logic [15:0] mPc, mNxtImId, mNxtIdEx, mRedir, mStall;
  logic [31:0] mCyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each IM word is a distinct function of its address.
  function automatic logic [16:0] imWord(input logic [15:0] a);
    return {^a, a ^ 16'h5A3C};
  endfunction

  always @(posedge clk) bus.im_rdata <= imWord(bus.iaddr);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mVld = 1'b0; mPc = 16'h0000; mNxtImId = 16'h0; mNxtIdEx = 16'h0;
    mCyc = 32'd0; mRedir = 16'h0; mStall = 16'h0;
  endtask

  function automatic logic [15:0] modelNextPc(input logic s, input logic f,
                                              input logic [15:0] d, input logic h);
    if (!mVld) return 16'h0000;
    if (f) return d;
    if (s || h) return mPc;
    return 16'(mPc + 16'd1);
  endfunction

  task automatic checkAll(input logic s, input logic f, input logic [15:0] d, input logic h);
    checkOutput("iaddr", 32'(bus.iaddr), 32'(modelNextPc(s, f, d, h)));
    checkOutput("instr", 32'(bus.instr), 32'(mVld ? imWord(mPc) : 17'h0));
    checkOutput("nxt_pc_ID_EX", 32'(bus.nxt_pc_ID_EX), 32'(mNxtIdEx));
    checkOutput("cyc_cnt", bus.cyc_cnt, mCyc);
    checkOutput("redir_cnt", 32'(bus.redir_cnt), 32'(mRedir));
    checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(mStall));
  endtask

  task automatic modelEdge(input logic s, input logic f, input logic [15:0] d, input logic h);
    logic [15:0] pcNext;
    pcNext   = modelNextPc(s, f, d, h);
    mNxtIdEx = mNxtImId;
    if (!s) mNxtImId = 16'(mPc + 16'd1);
    if (!h) begin
      mCyc = mCyc + 32'd1;
      if (f && mRedir != 16'hFFFF) mRedir = mRedir + 16'd1;
      if (s && !f && mStall != 16'hFFFF) mStall = mStall + 16'd1;
    end
    mPc  = pcNext;
    mVld = 1'b1;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic s, input logic f, input logic [15:0] d, input logic h);
    bus.stall_IM_ID       = s;
    bus.flow_change_ID_EX = f;
    bus.dst_ID_EX         = d;
    bus.hlt_DM_WB         = h;
    #1;
    checkAll(s, f, d, h);
    @(posedge clk);
    modelEdge(s, f, d, h);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    logic [31:0] cycFrozen;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.stall_IM_ID = 1'b0;
    bus.flow_change_ID_EX = 1'b0;
    bus.dst_ID_EX = 16'h0;
    bus.hlt_DM_WB = 1'b0;
    modelReset();
    $display("[TB] fetch_pc bench starting");

    repeat (3) @(negedge clk);
    #1;
    checkAll(1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from reset up to pc=5, then redirect to 0x40.
    guard = 0;
    while (!(mVld && mPc == 16'h0005) && guard < 20) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
      guard++;
    end
    checkOutput("reach_pc5", 32'(guard), 32'd6);
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0);
    checkOutput("redir_pc", 32'(mPc), 32'h40);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0007, 1'b0);

    // Three-cycle stall at pc=7.
    repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("stall_cnt3", 32'(bus.stall_cnt), 32'd3);
    repeat (2) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    // Redirect wins over simultaneous stall.
    applyStimulus(1'b1, 1'b1, 16'h0010, 1'b0);
    checkOutput("stall_redir_pc", 32'(mPc), 32'h10);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    // PC wrap FFFF -> 0000.
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    // Random traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkAll(bus.stall_IM_ID, bus.flow_change_ID_EX, bus.dst_ID_EX, bus.hlt_DM_WB);
        @(negedge clk);
        rst_n = 1'b1;
      end
      applyStimulus(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
                    16'($urandom), 1'b0);
    end

    // Redirect counter saturation.
    force dut.redir_cnt_q = 16'hFFFF;
    #1;
    release dut.redir_cnt_q;
    mRedir = 16'hFFFF;
    applyStimulus(1'b0, 1'b1, 16'h0020, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0030, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    // Halt freezes pc and counters.
    cycFrozen = mCyc;
    for (int i = 0; i < 10; i++)
      applyStimulus(($urandom_range(0, 1) == 1), 1'b0, 16'h0, 1'b1);
    checkOutput("halt_cyc_frozen", bus.cyc_cnt, cycFrozen);
    #1;
    checkAll(1'b0, 1'b0, 16'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_pc.md
# fetch_pc

Instruction-fetch stage of the 17-bit-instruction pipelined CPU. It sits directly upstream of the instruction decoder. It owns the PC register and drives the address of the synchronous instruction memory (IM). It also presents the fetched instruction to the decoder's IM_ID flop and pipelines next-PC alongside it for the EX stage (JAL/branch source NPC2SRC1). Three performance counters are provided: cycles, redirects and fetch stalls.

## Interface
Parameters:
- PC_W, 16, PC and IM address width
- RESET_VEC, 0, first fetch address after reset

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall_IM_ID  in  1  decoder stall (load-use, HLT in ID_EX, MOVC); hold fetch
- flow_change_ID_EX  in  1  taken branch/JAL/JR resolved in EX; redirect
- dst_ID_EX  in  PC_W  redirect target
- hlt_DM_WB  in  1  halt reached WB; freeze fetch and counters
- iaddr  out  PC_W  IM read address (combinational pc_nxt)
- im_rdata  in  17  IM read data; valid one cycle after iaddr is sampled
- instr  out  17  instruction to decoder
- nxt_pc_ID_EX  out  PC_W  PC+1 of the instruction currently in EX
- cyc_cnt  out  32  cycles since reset
- redir_cnt  out  16  redirect count, saturating
- stall_cnt  out  16  stalled-fetch cycles, saturating

## Operation
- State:
  - fetch_vld: 1 bit, reset 0.
  - pc: reset RESET_VEC. Holds the address whose data is on im_rdata.
  - nxt_pc_IM_ID: reset 0.
  - nxt_pc_ID_EX: reset 0.
  - cyc_cnt, redir_cnt, stall_cnt: reset 0.
- pc_nxt priority (highest first):
  1. !fetch_vld → RESET_VEC
  2. flow_change_ID_EX → dst_ID_EX
  3. stall_IM_ID or hlt_DM_WB → pc
  4. otherwise → pc+1, wrapping modulo 2^PC_W (FFFF→0000)
- iaddr = pc_nxt. IM latches iaddr on the same edge that pc latches pc_nxt, so im_rdata always corresponds to pc.
- Each edge: pc ← pc_nxt; fetch_vld ← 1.
- instr = fetch_vld ? im_rdata : 17'h00000. The forced value is LLB R0,#0, which matches the decoder's reset instruction.
- nxt_pc_IM_ID ← pc+1 when !stall_IM_ID. This uses the same enable as the decoder's IM_ID flop, so it stays aligned with instr_IM_ID.
- nxt_pc_ID_EX ← nxt_pc_IM_ID every edge (the ID_EX stage never stalls).
- Redirect beats stall. The two younger in-flight instructions are flushed by the decoder, not here.
- During a stall, iaddr = pc, so the IM re-reads the same word and instr stays stable.
- Counters:
  - cyc_cnt: +1 per cycle while !hlt_DM_WB; wraps.
  - redir_cnt: +1 per cycle with flow_change_ID_EX; saturates at FFFF.
  - stall_cnt: +1 per cycle with stall_IM_ID & !flow_change_ID_EX; saturates at FFFF.
  - All three freeze while hlt_DM_WB.

## Timing
- Reset outputs: iaddr = RESET_VEC, instr = 0, nxt_pc_ID_EX = 0, all counters 0.
- After deassertion:
  - Edge 1: fetch_vld=1, pc=RESET_VEC, IM read at RESET_VEC.
  - The next edge latches instr at RESET_VEC into the decoder.
- Redirect: flow_change_ID_EX high in cycle N → iaddr=dst in N → instr=mem[dst] in N+1.
- Stall: stall_IM_ID high in cycle N → pc, instr and nxt_pc_IM_ID are unchanged at the end of N. Fetch resumes the cycle after stall drops.
- Reset asserted mid-operation: all state clears immediately (asynchronous). The fetch sequence restarts at RESET_VEC.
- Simultaneous redirect + stall: redirect taken, stall_cnt not incremented, redir_cnt incremented.
- hlt_DM_WB high: pc and counters frozen indefinitely until reset.
- nxt_pc_ID_EX latency: value is pc+1 of the instruction currently in EX (two edges after it was presented on instr, absent stall).

## Test plan
- Reset release with mem[0..3]=A,B,C,D:
  - instr=0 in the reset cycle.
  - Then A,B,C,D on consecutive cycles.
  - iaddr sequence 0,1,2,3,4.
  - nxt_pc_ID_EX = 1 two cycles after A is presented.
- Redirect: at pc=5 assert flow_change_ID_EX with dst=0x40 for one cycle.
  - iaddr=0x40 in that cycle; instr=mem[0x40] next cycle.
  - redir_cnt=1.
- Stall: assert stall_IM_ID for 3 cycles at pc=7.
  - instr and iaddr held at 7 for 3 cycles, then 8.
  - stall_cnt=3.
  - nxt_pc_IM_ID unchanged at 7 during the stall.
- Simultaneous stall + flow_change (dst=0x10):
  - pc←0x10.
  - stall_cnt unchanged, redir_cnt +1.
- Wrap: pc=FFFF, no stall → next iaddr=0000.
- Halt and counter saturation:
  - hlt_DM_WB asserted → pc and cyc_cnt frozen for 10 cycles.
  - Preload redir_cnt to FFFF by force, then redirect → stays FFFF.
